lsu: RTL and testbench

Load/store unit sitting directly downstream of the execute stage: takes the ALU-computed effective address plus store data, runs one memory transaction over a valid/ready request and response bus, and returns aligned, sign/zero-extended load data for regfile write-back. It holds the core busy through a multi-cycle FSM. Loads/stores are RV32I/E sizes B/H/W; misaligned or illegal-size accesses fault without touching memory.

---
 rtl/lsu_pkg.sv | 9 +
 rtl/lsu_fmt.sv | 40 ++++
 rtl/lsu.sv | 100 ++++++++++
 tb/tb_lsu.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size codes and FSM state encoding for the load/store unit
package lsu_pkg;
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/lsu_fmt.sv
// lsu_fmt: store lane/strobe generation, fault detection and load extract/extend
module lsu_fmt
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]          funct3,
    input  logic                store,
    input  logic [1:0]          off,
    input  logic [DATA_W-1:0]   rs2,
    input  logic [2:0]          ld_funct3,
    input  logic [1:0]          ld_off,
    input  logic [DATA_W-1:0]   rdata,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   ldata,
    output logic                fault
);
    logic illegal, misaligned, sx;
    logic [7:0]  b;
    logic [15:0] h;

    assign illegal    = store ? !(funct3 inside {LSU_B, LSU_H, LSU_W})
                              : !(funct3 inside {LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU});
    assign misaligned = ((funct3 == LSU_H || funct3 == LSU_HU) && off[0]) ||
                        (funct3 == LSU_W && off != 2'b00);
    assign fault      = illegal | misaligned;

    assign wstrb = !store           ? '0 :
                   funct3 == LSU_B  ? (DATA_W/8)'(1) << off :
                   funct3 == LSU_H  ? (DATA_W/8)'(3) << off : '1;
    assign wdata = funct3 == LSU_B  ? DATA_W'(rs2[7:0]) << {off, 3'b000} :
                   funct3 == LSU_H  ? DATA_W'(rs2[15:0]) << {off, 3'b000} : rs2;

    assign b     = rdata[{ld_off, 3'b000} +: 8];
    assign h     = rdata[{ld_off[1], 4'b0000} +: 16];
    assign sx    = ld_funct3 == LSU_B || ld_funct3 == LSU_H;
    assign ldata = (ld_funct3 == LSU_B || ld_funct3 == LSU_BU) ? {{(DATA_W-8){sx & b[7]}}, b} :
                   (ld_funct3 == LSU_H || ld_funct3 == LSU_HU) ? {{(DATA_W-16){sx & h[15]}}, h} : rdata;
endmodule

// File: rtl/lsu.sv
// lsu: single-transaction load/store unit with valid/ready memory bus
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_exu_valid,
    output logic                o_lsu_ready,
    input  logic                i_idu_load,
    input  logic                i_idu_store,
    input  logic [2:0]          i_idu_funct3,
    input  logic [ADDR_W-1:0]   i_exu_addr,
    input  logic [DATA_W-1:0]   i_idu_rs2_data,
    output logic                o_mem_req_valid,
    input  logic                i_mem_req_ready,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic                o_mem_wen,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_wstrb,
    input  logic                i_mem_rsp_valid,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_lsu_valid,
    output logic [DATA_W-1:0]   o_lsu_rdata,
    output logic                o_lsu_fault
);
    state_t state, state_n;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          f3_q;
    logic                store_q, fault_q, accept, f_fault;
    logic [DATA_W-1:0]   wdata_q, rdata_q, f_wdata, f_ldata;
    logic [DATA_W/8-1:0] wstrb_q, f_wstrb;

    assign accept = state == S_IDLE && i_exu_valid && (i_idu_load || i_idu_store);

    lsu_fmt #(.DATA_W(DATA_W)) u_fmt (
        .funct3    (i_idu_funct3),
        .store     (i_idu_store),
        .off       (i_exu_addr[1:0]),
        .rs2       (i_idu_rs2_data),
        .ld_funct3 (f3_q),
        .ld_off    (addr_q[1:0]),
        .rdata     (i_mem_rdata),
        .wdata     (f_wdata),
        .wstrb     (f_wstrb),
        .ldata     (f_ldata),
        .fault     (f_fault)
    );

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_n;
    end

    // next-state: faults skip the bus and complete straight away
    always_comb begin
        state_n = state;
        if (accept)                                  state_n = f_fault ? S_DONE : S_REQ;
        else if (state == S_REQ && i_mem_req_ready)  state_n = S_WAIT;
        else if (state == S_WAIT && i_mem_rsp_valid) state_n = S_DONE;
        else if (state == S_DONE)                    state_n = S_IDLE;
    end

    // request latches on accept, result latch on response
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q  <= '0;
            f3_q    <= '0;
            store_q <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= i_exu_addr;
                f3_q    <= i_idu_funct3;
                store_q <= i_idu_store;
                wdata_q <= f_wdata;
                wstrb_q <= f_wstrb;
                fault_q <= f_fault;
                if (f_fault) rdata_q <= '0;
            end
            if (state == S_WAIT && i_mem_rsp_valid) rdata_q <= store_q ? '0 : f_ldata;
        end
    end

    assign o_lsu_ready     = state == S_IDLE;
    assign o_mem_req_valid = state == S_REQ;
    assign o_mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
    assign o_mem_wen       = store_q;
    assign o_mem_wdata     = wdata_q;
    assign o_mem_wstrb     = wstrb_q;
    assign o_lsu_valid     = state == S_DONE;
    assign o_lsu_fault     = fault_q && state == S_DONE;
    assign o_lsu_rdata     = rdata_q;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: table-driven check of the load/store unit plus stall and reset sequences
module tb_lsu;
    logic        clk = 1'b0, rst = 1'b1;
    logic        exu_valid = 1'b0, lsu_ready, ld = 1'b0, st = 1'b0;
    logic [2:0]  f3 = 3'b0;
    logic [31:0] addr = '0, rs2 = '0;
    logic        req_valid, req_ready = 1'b0, wen, rsp_valid = 1'b0, lsu_valid, lsu_fault;
    logic [31:0] mem_addr, wdata, rdata = '0, lsu_rdata;
    logic [3:0]  wstrb;
    int          errors = 0, checks = 0;

    typedef struct {
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] addr, rs2, rdata, e_addr, e_wdata, e_rdata;
        logic [3:0]  e_wstrb;
        logic        e_fault;
    } vec_t;

    vec_t v[14];

    lsu dut (
        .i_clk(clk), .i_rst(rst), .i_exu_valid(exu_valid), .o_lsu_ready(lsu_ready),
        .i_idu_load(ld), .i_idu_store(st), .i_idu_funct3(f3), .i_exu_addr(addr),
        .i_idu_rs2_data(rs2), .o_mem_req_valid(req_valid), .i_mem_req_ready(req_ready),
        .o_mem_addr(mem_addr), .o_mem_wen(wen), .o_mem_wdata(wdata), .o_mem_wstrb(wstrb),
        .i_mem_rsp_valid(rsp_valid), .i_mem_rdata(rdata), .o_lsu_valid(lsu_valid),
        .o_lsu_rdata(lsu_rdata), .o_lsu_fault(lsu_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic run_vec(input vec_t x, input int i);
        chk($sformatf("v%0d ready_idle", i), 32'(lsu_ready), 1);
        exu_valid = 1; ld = x.ld; st = x.st; f3 = x.f3; addr = x.addr; rs2 = x.rs2; req_ready = 1;
        @(negedge clk);
        exu_valid = 0; ld = 0; st = 0;
        if (x.e_fault) begin
            chk($sformatf("v%0d fault_valid", i), 32'(lsu_valid), 1);
            chk($sformatf("v%0d fault_flag", i), 32'(lsu_fault), 1);
            chk($sformatf("v%0d fault_noreq", i), 32'(req_valid), 0);
            chk($sformatf("v%0d fault_rdata", i), lsu_rdata, 0);
        end else begin
            chk($sformatf("v%0d req_valid", i), 32'(req_valid), 1);
            chk($sformatf("v%0d mem_addr", i), mem_addr, x.e_addr);
            chk($sformatf("v%0d wen", i), 32'(wen), 32'(x.st));
            chk($sformatf("v%0d wstrb", i), 32'(wstrb), 32'(x.e_wstrb));
            chk($sformatf("v%0d wdata", i), wdata, x.e_wdata);
            chk($sformatf("v%0d busy", i), 32'(lsu_ready), 0);
            @(negedge clk);
            chk($sformatf("v%0d no_early_valid", i), 32'(lsu_valid), 0);
            rsp_valid = 1; rdata = x.rdata;
            @(negedge clk);
            rsp_valid = 0;
            chk($sformatf("v%0d done_valid", i), 32'(lsu_valid), 1);
            chk($sformatf("v%0d done_fault", i), 32'(lsu_fault), 0);
            chk($sformatf("v%0d done_rdata", i), lsu_rdata, x.e_rdata);
        end
        @(negedge clk);
        chk($sformatf("v%0d pulse_end", i), 32'(lsu_valid), 0);
    endtask

    initial begin
        //        ld st f3      addr          rs2           rdata         e_addr        e_wdata       e_rdata       strb  flt
        v[0]  = '{0, 1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h1234_5678, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0,        4'hF, 0};
        v[1]  = '{1, 0, 3'b000, 32'h8000_0003, 32'h0,        32'h8011_2233, 32'h8000_0000, 32'h0,        32'hFFFF_FF80, 4'h0, 0};
        v[2]  = '{1, 0, 3'b100, 32'h8000_0003, 32'h0,        32'h8011_2233, 32'h8000_0000, 32'h0,        32'h0000_0080, 4'h0, 0};
        v[3]  = '{1, 0, 3'b101, 32'h8000_0002, 32'h0,        32'h8011_2233, 32'h8000_0000, 32'h0,        32'h0000_8011, 4'h0, 0};
        v[4]  = '{1, 0, 3'b001, 32'h8000_0002, 32'h0,        32'h8011_2233, 32'h8000_0000, 32'h0,        32'hFFFF_8011, 4'h0, 0};
        v[5]  = '{0, 1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'h0,        32'h8000_0000, 32'hABCD_0000, 32'h0,        4'hC, 0};
        v[6]  = '{0, 1, 3'b000, 32'h8000_0001, 32'h1234_56A5, 32'h0,        32'h8000_0000, 32'h0000_A500, 32'h0,        4'h2, 0};
        v[7]  = '{1, 0, 3'b010, 32'h8000_0008, 32'h0,        32'hCAFE_F00D, 32'h8000_0008, 32'h0,        32'hCAFE_F00D, 4'h0, 0};
        v[8]  = '{1, 0, 3'b010, 32'h8000_0002, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        4'h0, 1};
        v[9]  = '{1, 0, 3'b001, 32'h8000_0001, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        4'h0, 1};
        v[10] = '{1, 0, 3'b011, 32'h8000_0000, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        4'h0, 1};
        v[11] = '{0, 1, 3'b100, 32'h8000_0000, 32'h5555_5555, 32'h0,        32'h0,        32'h0,        32'h0,        4'h0, 1};
        v[12] = '{1, 0, 3'b000, 32'h8000_0000, 32'h0,        32'h0000_007F, 32'h8000_0000, 32'h0,        32'h0000_007F, 4'h0, 0};
        v[13] = '{1, 0, 3'b101, 32'h8000_0000, 32'h0,        32'h1234_F00D, 32'h8000_0000, 32'h0,        32'h0000_F00D, 4'h0, 0};

        @(negedge clk);
        @(negedge clk);
        chk("rst ready", 32'(lsu_ready), 1);
        chk("rst req_valid", 32'(req_valid), 0);
        chk("rst lsu_valid", 32'(lsu_valid), 0);
        chk("rst fault", 32'(lsu_fault), 0);
        chk("rst rdata", lsu_rdata, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst wdata", wdata, 0);
        chk("rst wstrb", 32'(wstrb), 0);
        chk("rst wen", 32'(wen), 0);
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run_vec(v[i], i);

        exu_valid = 1; ld = 0; st = 0; addr = 32'h40;
        @(negedge clk);
        exu_valid = 0;
        chk("nop ready", 32'(lsu_ready), 1);
        chk("nop req", 32'(req_valid), 0);

        exu_valid = 1; ld = 1; f3 = 3'b010; addr = 32'h20; req_ready = 1;
        @(negedge clk);
        exu_valid = 0; ld = 0;
        chk("rstw req", 32'(req_valid), 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rstw ready", 32'(lsu_ready), 1);
        chk("rstw req_valid", 32'(req_valid), 0);
        chk("rstw lsu_valid", 32'(lsu_valid), 0);
        chk("rstw rdata", lsu_rdata, 0);
        @(negedge clk);
        rsp_valid = 1; rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        rsp_valid = 0;
        chk("rstw late_rsp", 32'(lsu_valid), 0);
        chk("rstw late_ready", 32'(lsu_ready), 1);
        @(negedge clk);
        chk("rstw late_rsp2", 32'(lsu_valid), 0);

        exu_valid = 1; st = 1; f3 = 3'b010; addr = 32'h10; rs2 = 32'h1122_3344; req_ready = 0;
        @(negedge clk);
        exu_valid = 0; st = 0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("stall%0d req_valid", k), 32'(req_valid), 1);
            chk($sformatf("stall%0d addr", k), mem_addr, 32'h10);
            chk($sformatf("stall%0d wdata", k), wdata, 32'h1122_3344);
            chk($sformatf("stall%0d wstrb", k), 32'(wstrb), 32'hF);
            chk($sformatf("stall%0d ready", k), 32'(lsu_ready), 0);
            exu_valid = (k == 2 || k == 3); ld = exu_valid; addr = 32'h44; rsp_valid = (k == 3);
            if (k == 4) req_ready = 1;
            @(negedge clk);
        end
        exu_valid = 0; ld = 0; rsp_valid = 0;
        chk("stall wait_novalid", 32'(lsu_valid), 0);
        rsp_valid = 1;
        @(negedge clk);
        rsp_valid = 0;
        chk("stall done_valid", 32'(lsu_valid), 1);
        chk("stall done_rdata", lsu_rdata, 0);
        chk("stall done_fault", 32'(lsu_fault), 0);
        @(negedge clk);
        chk("stall back_ready", 32'(lsu_ready), 1);
        chk("stall pulse_end", 32'(lsu_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
